slink_gpio_serdes_ctrl: RTL

Power/enable sequencer for the GPIO serdes. Drives the serdes level-enable inputs (clk_en, clk_idle, tx_en, rx_en) in the required order and waits on the matching synchronized ready levels. Supports idle entry and exit, and orderly or aborted shutdown. A watchdog timeout on every handshake forces a safe ERROR state. Sits in the link-layer clock domain between the LTSSM-level enable/idle requests and the serdes.

---
 rtl/slink_gpio_pkg.sv | 30 +++
 rtl/slink_gpio_serdes_ctrl_cnt.sv | 26 ++
 rtl/slink_gpio_serdes_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/slink_gpio_pkg.sv
// Shared definitions for the GPIO serdes enable sequencer: state encoding and width.
package slink_gpio_pkg;

    localparam int SLINK_GPIO_ST_W = 4;

    localparam logic [SLINK_GPIO_ST_W-1:0] SLINK_GPIO_ST_OFF      = 4'd0;
    localparam logic [SLINK_GPIO_ST_W-1:0] SLINK_GPIO_ST_CLK_ON   = 4'd1;
    localparam logic [SLINK_GPIO_ST_W-1:0] SLINK_GPIO_ST_TXRX_ON  = 4'd2;
    localparam logic [SLINK_GPIO_ST_W-1:0] SLINK_GPIO_ST_SETTLE   = 4'd3;
    localparam logic [SLINK_GPIO_ST_W-1:0] SLINK_GPIO_ST_ACTIVE   = 4'd4;
    localparam logic [SLINK_GPIO_ST_W-1:0] SLINK_GPIO_ST_IDLE     = 4'd5;
    localparam logic [SLINK_GPIO_ST_W-1:0] SLINK_GPIO_ST_WAKE     = 4'd6;
    localparam logic [SLINK_GPIO_ST_W-1:0] SLINK_GPIO_ST_TXRX_OFF = 4'd7;
    localparam logic [SLINK_GPIO_ST_W-1:0] SLINK_GPIO_ST_CLK_OFF  = 4'd8;
    localparam logic [SLINK_GPIO_ST_W-1:0] SLINK_GPIO_ST_ERROR    = 4'd9;

    typedef enum logic [SLINK_GPIO_ST_W-1:0] {
        ST_OFF      = SLINK_GPIO_ST_OFF,
        ST_CLK_ON   = SLINK_GPIO_ST_CLK_ON,
        ST_TXRX_ON  = SLINK_GPIO_ST_TXRX_ON,
        ST_SETTLE   = SLINK_GPIO_ST_SETTLE,
        ST_ACTIVE   = SLINK_GPIO_ST_ACTIVE,
        ST_IDLE     = SLINK_GPIO_ST_IDLE,
        ST_WAKE     = SLINK_GPIO_ST_WAKE,
        ST_TXRX_OFF = SLINK_GPIO_ST_TXRX_OFF,
        ST_CLK_OFF  = SLINK_GPIO_ST_CLK_OFF,
        ST_ERROR    = SLINK_GPIO_ST_ERROR
    } slink_gpio_state_t;

endpackage

// File: rtl/slink_gpio_serdes_ctrl_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module slink_gpio_serdes_ctrl_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value_reg <= '0;
        end else if (clr) begin
            value_reg <= '0;
        end else if (inc && (value_reg != {W{1'b1}})) begin
            value_reg <= value_reg + W'(1);
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/slink_gpio_serdes_ctrl.sv
// Serdes power/enable sequencer: orders clk/tx/rx enables, waits on ready levels,
// handles idle entry/exit and shutdown, and traps stuck handshakes in ERROR.
module slink_gpio_serdes_ctrl
    import slink_gpio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SETTLE_CYCLES  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       idle_req,
    input  logic                       tx_dir_en,
    input  logic                       rx_dir_en,
    output logic                       clk_en,
    output logic                       clk_idle,
    output logic                       tx_en,
    output logic                       rx_en,
    input  logic                       clk_ready,
    input  logic                       tx_ready,
    input  logic                       rx_ready,
    output logic                       active,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [SLINK_GPIO_ST_W-1:0] state
);

    localparam int MAX_CNT = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);

    slink_gpio_state_t state_reg, state_next;
    logic tx_sel_reg, tx_sel_next;
    logic rx_sel_reg, rx_sel_next;
    logic clk_en_reg, clk_en_next;
    logic clk_idle_reg, clk_idle_next;
    logic tx_en_reg, tx_en_next;
    logic rx_en_reg, rx_en_next;
    logic active_reg, active_next;
    logic busy_reg, busy_next;
    logic err_reg, err_next;

    logic [CW-1:0] cnt;
    logic          cnt_inc;
    logic          cnt_clr;
    logic          trx_ok;
    logic          timeout_hit;
    logic          settle_done;

    // Unused direction paths are treated as already matched.
    assign trx_ok      = (!tx_sel_reg || (tx_ready == tx_en_reg)) &&
                         (!rx_sel_reg || (rx_ready == rx_en_reg));
    assign timeout_hit = (cnt == TIMEOUT_LAST);
    assign settle_done = (cnt == SETTLE_LAST);

    always_comb begin
        state_next  = state_reg;
        tx_sel_next = tx_sel_reg;
        rx_sel_next = rx_sel_reg;
        case (state_reg)
            ST_OFF: begin
                if (enable) begin
                    state_next  = ST_CLK_ON;
                    tx_sel_next = tx_dir_en;
                    rx_sel_next = rx_dir_en;
                end
            end
            ST_CLK_ON: begin
                if (!enable)          state_next = ST_CLK_OFF;
                else if (clk_ready)   state_next = ST_TXRX_ON;
                else if (timeout_hit) state_next = ST_ERROR;
            end
            ST_TXRX_ON: begin
                if (!enable)          state_next = ST_TXRX_OFF;
                else if (trx_ok)      state_next = ST_SETTLE;
                else if (timeout_hit) state_next = ST_ERROR;
            end
            ST_SETTLE, ST_WAKE: begin
                if (!enable)          state_next = ST_TXRX_OFF;
                else if (settle_done) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!enable)          state_next = ST_TXRX_OFF;
                else if (idle_req)    state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (!enable)          state_next = ST_TXRX_OFF;
                else if (!idle_req)   state_next = ST_WAKE;
            end
            ST_TXRX_OFF: begin
                if (trx_ok)           state_next = ST_CLK_OFF;
                else if (timeout_hit) state_next = ST_ERROR;
            end
            ST_CLK_OFF: begin
                if (!clk_ready)       state_next = ST_OFF;
                else if (timeout_hit) state_next = ST_ERROR;
            end
            ST_ERROR: begin
                if (!enable)          state_next = ST_OFF;
            end
            default: state_next = ST_OFF;
        endcase
    end

    // Outputs are decoded from the next state so they move on the transition edge.
    always_comb begin
        clk_en_next   = 1'b0;
        clk_idle_next = 1'b0;
        tx_en_next    = 1'b0;
        rx_en_next    = 1'b0;
        active_next   = 1'b0;
        busy_next     = 1'b0;
        err_next      = 1'b0;
        case (state_next)
            ST_CLK_ON: begin
                clk_en_next = 1'b1;
                busy_next   = 1'b1;
            end
            ST_TXRX_ON, ST_SETTLE, ST_WAKE: begin
                clk_en_next = 1'b1;
                tx_en_next  = tx_sel_next;
                rx_en_next  = rx_sel_next;
                busy_next   = 1'b1;
            end
            ST_ACTIVE: begin
                clk_en_next = 1'b1;
                tx_en_next  = tx_sel_next;
                rx_en_next  = rx_sel_next;
                active_next = 1'b1;
            end
            ST_IDLE: begin
                clk_en_next   = 1'b1;
                clk_idle_next = 1'b1;
                tx_en_next    = tx_sel_next;
                rx_en_next    = rx_sel_next;
            end
            ST_TXRX_OFF: begin
                clk_en_next = 1'b1;
                busy_next   = 1'b1;
            end
            ST_CLK_OFF: busy_next = 1'b1;
            ST_ERROR:   err_next  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_OFF;
            tx_sel_reg   <= 1'b0;
            rx_sel_reg   <= 1'b0;
            clk_en_reg   <= 1'b0;
            clk_idle_reg <= 1'b0;
            tx_en_reg    <= 1'b0;
            rx_en_reg    <= 1'b0;
            active_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tx_sel_reg   <= tx_sel_next;
            rx_sel_reg   <= rx_sel_next;
            clk_en_reg   <= clk_en_next;
            clk_idle_reg <= clk_idle_next;
            tx_en_reg    <= tx_en_next;
            rx_en_reg    <= rx_en_next;
            active_reg   <= active_next;
            busy_reg     <= busy_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        cnt_inc = 1'b0;
        case (state_reg)
            ST_CLK_ON, ST_TXRX_ON, ST_SETTLE, ST_WAKE, ST_TXRX_OFF, ST_CLK_OFF: cnt_inc = 1'b1;
            default: cnt_inc = 1'b0;
        endcase
    end

    assign cnt_clr = (state_next != state_reg);

    slink_gpio_serdes_ctrl_cnt #(
        .W (CW)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .value   (cnt)
    );

    assign clk_en      = clk_en_reg;
    assign clk_idle    = clk_idle_reg;
    assign tx_en       = tx_en_reg;
    assign rx_en       = rx_en_reg;
    assign active      = active_reg;
    assign busy        = busy_reg;
    assign timeout_err = err_reg;
    assign state       = state_reg;

endmodule
